// File: rtl/div_sequencer.sv
// div_sequencer: multi-cycle RV32M DIV/DIVU/REM/REMU unit for the EX stage.
// Stalls the pipeline while a 32-step restoring division runs, resolves
// divide-by-zero and signed overflow without iterating, and returns a
// registered result together with a one-cycle done pulse.
module div_sequencer #(
    parameter int DATA_WIDTH   = 32,
    parameter int ALUCTR_WIDTH = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [ALUCTR_WIDTH-1:0] alu_ctrl,
    input  logic [DATA_WIDTH-1:0]   op_a,
    input  logic [DATA_WIDTH-1:0]   op_b,
    input  logic                    kill,
    output logic                    busy,
    output logic                    done,
    output logic [DATA_WIDTH-1:0]   result
);

    localparam int CW = $clog2(DATA_WIDTH);

    localparam logic [ALUCTR_WIDTH-1:0] CTRL_DIV  = ALUCTR_WIDTH'(5'b01110);
    localparam logic [ALUCTR_WIDTH-1:0] CTRL_DIVU = ALUCTR_WIDTH'(5'b01111);
    localparam logic [ALUCTR_WIDTH-1:0] CTRL_REM  = ALUCTR_WIDTH'(5'b10000);
    localparam logic [ALUCTR_WIDTH-1:0] CTRL_REMU = ALUCTR_WIDTH'(5'b10001);

    localparam logic [DATA_WIDTH-1:0] MIN_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [CW-1:0]         LAST_STEP = CW'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } state_t;

    state_t state, state_next;

    logic [CW-1:0]         cnt;
    logic [DATA_WIDTH-1:0] dvd;      // dividend magnitude, shifted out MSB first
    logic [DATA_WIDTH-1:0] dvs;      // divisor magnitude
    logic [DATA_WIDTH-1:0] rem;      // partial remainder (always < dvs)
    logic [DATA_WIDTH-1:0] quo;
    logic                  is_rem;
    logic                  neg_q;
    logic                  neg_r;

    logic                  req_valid;
    logic                  op_signed;
    logic                  op_rem;
    logic                  div_zero;
    logic                  sgn_ovf;
    logic                  special;
    logic [DATA_WIDTH-1:0] a_abs;
    logic [DATA_WIDTH-1:0] b_abs;
    logic [DATA_WIDTH:0]   shifted;
    logic [DATA_WIDTH:0]   trial;
    logic [DATA_WIDTH-1:0] q_fixed;
    logic [DATA_WIDTH-1:0] r_fixed;

    // Request decode, special-case detection and one restoring step.
    always_comb begin
        op_signed = (alu_ctrl == CTRL_DIV) || (alu_ctrl == CTRL_REM);
        op_rem    = (alu_ctrl == CTRL_REM) || (alu_ctrl == CTRL_REMU);
        req_valid = start && (op_signed || (alu_ctrl == CTRL_DIVU) ||
                              (alu_ctrl == CTRL_REMU));
        div_zero  = (op_b == '0);
        sgn_ovf   = op_signed && (op_a == MIN_NEG) && (op_b == '1);
        special   = div_zero || sgn_ovf;
        a_abs     = (op_signed && op_a[DATA_WIDTH-1]) ? -op_a : op_a;
        b_abs     = (op_signed && op_b[DATA_WIDTH-1]) ? -op_b : op_b;
        shifted   = {rem, dvd[DATA_WIDTH-1]};
        trial     = shifted - {1'b0, dvs};
        q_fixed   = neg_q ? -quo : quo;
        r_fixed   = neg_r ? -rem : rem;
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state logic and handshake outputs.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        if (kill) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: if (req_valid) state_next = special ? DONE : CALC;
                CALC: if (cnt == LAST_STEP) state_next = FIX;
                FIX:  state_next = DONE;
                DONE: state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
        busy = (state == CALC) || (state == FIX) ||
               ((state == IDLE) && req_valid && !kill);
        done = (state == DONE) && !kill;
    end

    // Datapath: operand capture, iteration, sign correction, result write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            dvd    <= '0;
            dvs    <= '0;
            rem    <= '0;
            quo    <= '0;
            is_rem <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            result <= '0;
        end else if (!kill) begin
            case (state)
                IDLE: if (req_valid) begin
                    if (div_zero) begin
                        result <= op_rem ? op_a : '1;
                    end else if (sgn_ovf) begin
                        result <= op_rem ? '0 : MIN_NEG;
                    end else begin
                        cnt    <= '0;
                        dvd    <= a_abs;
                        dvs    <= b_abs;
                        rem    <= '0;
                        quo    <= '0;
                        is_rem <= op_rem;
                        neg_q  <= op_signed && (op_a[DATA_WIDTH-1] ^ op_b[DATA_WIDTH-1]);
                        neg_r  <= op_signed && op_a[DATA_WIDTH-1];
                    end
                end
                CALC: begin
                    cnt <= cnt + 1'b1;
                    dvd <= dvd << 1;
                    if (!trial[DATA_WIDTH]) begin
                        rem <= trial[DATA_WIDTH-1:0];
                        quo <= {quo[DATA_WIDTH-2:0], 1'b1};
                    end else begin
                        rem <= shifted[DATA_WIDTH-1:0];
                        quo <= {quo[DATA_WIDTH-2:0], 1'b0};
                    end
                end
                FIX: result <= is_rem ? r_fixed : q_fixed;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_sequencer.sv
// Self-checking bench for div_sequencer: directed cases plus randomized
// divides compared against an arithmetic reference model.
module tb_div_sequencer;

    localparam logic [4:0] C_DIV  = 5'b01110;
    localparam logic [4:0] C_DIVU = 5'b01111;
    localparam logic [4:0] C_REM  = 5'b10000;
    localparam logic [4:0] C_REMU = 5'b10001;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [4:0]  alu_ctrl;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        kill;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;
    logic [31:0] last_res;

    div_sequencer #(.DATA_WIDTH(32), .ALUCTR_WIDTH(5)) dut (
        .clk(clk), .rst(rst), .start(start), .alu_ctrl(alu_ctrl),
        .op_a(op_a), .op_b(op_b), .kill(kill),
        .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic bit is_special(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b);
        bit sgn = (c == C_DIV) || (c == C_REM);
        return (b == 0) || (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    function automatic logic [31:0] model(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b);
        bit want_rem = (c == C_REM) || (c == C_REMU);
        bit sgn      = (c == C_DIV) || (c == C_REM);
        int sa, sb;
        if (b == 0) return want_rem ? a : 32'hFFFF_FFFF;
        if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return want_rem ? 32'h0 : 32'h8000_0000;
        if (sgn) begin
            sa = $signed(a);
            sb = $signed(b);
            return want_rem ? 32'(sa % sb) : 32'(sa / sb);
        end
        return want_rem ? (a % b) : (a / b);
    endfunction

    // Issue one request and follow it to completion, checking stall, latency and value.
    task automatic do_op(input string tag, input logic [4:0] c, input logic [31:0] a,
                         input logic [31:0] b, input bit hold_start);
        int lat;
        int exp_lat;
        logic [31:0] exp_res;
        exp_lat = is_special(c, a, b) ? 1 : 34;
        exp_res = model(c, a, b);
        @(negedge clk);
        start = 1'b1; alu_ctrl = c; op_a = a; op_b = b;
        #1 check({tag, "_busy_req"}, 32'(busy), 32'd1);
        @(posedge clk);
        lat = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!hold_start) start = 1'b0;
            lat++;
            #1;
            if (done) break;
            check({tag, "_busy_run"}, 32'(busy), 32'd1);
        end
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_busy_done"}, 32'(busy), 32'd0);
        check({tag, "_result"}, result, exp_res);
        @(negedge clk);
        start = 1'b0;
        #1 check({tag, "_done_pulse"}, 32'(done), 32'd0);
        check({tag, "_idle_busy"}, 32'(busy), 32'd0);
        check({tag, "_hold"}, result, exp_res);
        last_res = exp_res;
    endtask

    initial begin
        logic [4:0]  codes [4];
        logic [4:0]  c;
        logic [31:0] a, b;
        codes[0] = C_DIV; codes[1] = C_DIVU; codes[2] = C_REM; codes[3] = C_REMU;

        rst = 1'b1; start = 1'b0; kill = 1'b0; alu_ctrl = '0; op_a = '0; op_b = '0;
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", result, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        do_op("divu_100_7", C_DIVU, 32'd100, 32'd7, 1'b0);
        do_op("rem_m7_2", C_REM, 32'hFFFF_FFF9, 32'd2, 1'b0);
        do_op("div_m7_2", C_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
        do_op("div_by0", C_DIV, 32'd55, 32'd0, 1'b0);
        do_op("remu_by0", C_REMU, 32'h1234, 32'd0, 1'b0);
        do_op("div_ovf", C_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        do_op("rem_ovf", C_REM, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        do_op("divu_big", C_DIVU, 32'hFFFF_FFFF, 32'd1, 1'b0);

        // Non-divide code must not stall or complete.
        @(negedge clk);
        start = 1'b1; alu_ctrl = 5'b01010; op_a = 32'd6; op_b = 32'd3;
        #1 check("mul_busy", 32'(busy), 32'd0);
        @(negedge clk);
        start = 1'b0;
        #1 check("mul_done", 32'(done), 32'd0);
        check("mul_busy2", 32'(busy), 32'd0);

        // Reset in the middle of CALC.
        @(negedge clk);
        start = 1'b1; alu_ctrl = C_DIV; op_a = 32'd1000; op_b = 32'd7;
        @(posedge clk);
        repeat (10) @(negedge clk);
        start = 1'b0;
        #1 check("pre_rst_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1 check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_result", result, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            #1 check("post_rst_nodone", 32'(done) | 32'(busy), 32'd0);
        end
        do_op("divu_9_3", C_DIVU, 32'd9, 32'd3, 1'b0);

        // Kill during FIX: back to IDLE, no done, result untouched.
        @(negedge clk);
        start = 1'b1; alu_ctrl = C_DIVU; op_a = 32'd500; op_b = 32'd3;
        @(posedge clk);
        repeat (33) @(negedge clk);
        start = 1'b0;
        #1 check("fix_busy", 32'(busy), 32'd1);
        kill = 1'b1;
        #1 check("kill_done", 32'(done), 32'd0);
        @(negedge clk);
        kill = 1'b0;
        #1 check("kill_idle_busy", 32'(busy), 32'd0);
        check("kill_no_done", 32'(done), 32'd0);
        check("kill_result", result, last_res);
        repeat (3) @(negedge clk);
        #1 check("kill_later_done", 32'(done), 32'd0);
        check("kill_later_res", result, last_res);

        // Kill and start together in IDLE: request refused.
        @(negedge clk);
        start = 1'b1; kill = 1'b1; alu_ctrl = C_DIV; op_a = 32'd20; op_b = 32'd0;
        #1 check("killstart_busy", 32'(busy), 32'd0);
        @(negedge clk);
        start = 1'b0; kill = 1'b0;
        #1 check("killstart_idle", 32'(busy), 32'd0);
        check("killstart_done", 32'(done), 32'd0);
        check("killstart_res", result, last_res);

        // Start held through DONE: no second launch.
        do_op("hold_start", C_DIVU, 32'd100, 32'd7, 1'b1);
        repeat (3) begin
            @(negedge clk);
            #1 check("hold_no_relaunch", 32'(busy) | 32'(done), 32'd0);
        end

        // Randomized operations.
        for (int n = 0; n < 24; n++) begin
            c = codes[$urandom_range(0, 3)];
            a = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 15));
                2: b = -32'($urandom_range(1, 15));
                default: b = $urandom;
            endcase
            if (n == 5) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            do_op("rand", c, a, b, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/div_sequencer.md
# div_sequencer

Multi-cycle sequencer and iterative datapath for the RV32M divide/remainder operations (DIV, DIVU, REM, REMU) in the EX stage. The ALU decoder emits these control codes. The single-cycle ALU cannot complete them, so this block takes over. It holds the pipeline with a stall signal, runs a 32-iteration restoring division, applies sign correction, and returns a registered result with a one-cycle completion pulse. Multiply codes stay in the ALU; this block ignores them.

## Interface
- DATA_WIDTH, 32, operand/result width (iteration count equals DATA_WIDTH)
- ALUCTR_WIDTH, 5, width of ALU control code
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  EX stage holds a candidate divide instruction this cycle
- alu_ctrl  input  ALUCTR_WIDTH  01110 DIV, 01111 DIVU, 10000 REM, 10001 REMU; any other code suppresses start
- op_a  input  DATA_WIDTH  dividend
- op_b  input  DATA_WIDTH  divisor
- kill  input  1  pipeline flush; aborts any operation in flight
- busy  output  1  stall request to the hazard unit
- done  output  1  one-cycle pulse; result valid
- result  output  DATA_WIDTH  quotient or remainder, registered

## Operation
- Valid request: start=1 and alu_ctrl is one of the four divide codes, while in IDLE. start is ignored in all other states.
- The FSM has four states:
  - IDLE: a valid request with a normal case loads the operands and moves to CALC. A valid request with a special case loads result directly and moves to DONE.
  - CALC: one restoring step per cycle, counter 0..DATA_WIDTH-1. When the counter reaches DATA_WIDTH-1 the FSM moves to FIX.
  - FIX: applies sign correction, writes result, moves to DONE.
  - DONE: done=1. The FSM always returns to IDLE. start is ignored here because the same instruction is still in EX.
- Signed ops (DIV, REM) run on absolute values. Sign correction:
  - The quotient is negated when the operand signs differ.
  - The remainder takes the dividend's sign.
  - Unsigned ops get no correction.
- Step arithmetic: the partial remainder is DATA_WIDTH+1 bits wide.
  - Shift in the next dividend bit (MSB first), then trial-subtract the divisor.
  - If the result is non-negative, keep it and set the quotient bit. Otherwise, restore and clear the quotient bit.
- Special cases resolve in IDLE with no CALC cycles:
  - Divisor 0: quotient all ones, remainder = op_a, for both signed and unsigned.
  - Signed overflow (op_a=0x80000000, op_b=0xFFFFFFFF, DIV/REM only): quotient 0x80000000, remainder 0.
- busy = (state==CALC or FIX) or (state==IDLE and valid request). The start term is combinational so the requesting cycle stalls. busy is 0 in DONE, so the pipeline advances at the end of the DONE cycle and captures result.
- kill: at the next edge, any state returns to IDLE and result is not updated. While kill=1, the start term of busy is forced to 0 and done is forced to 0.
- result holds its last value until the next completion.

## Timing
- Reset, asynchronous: state=IDLE, counter=0, internal registers=0, result=0, done=0, busy=0.
- Reset mid-operation: outputs drop immediately and no done is produced. The first request after reset is accepted normally.
- Normal latency, with the valid request sampled at edge N:
  - CALC occupies edges N+1..N+32.
  - FIX is at edge N+33.
  - DONE is the cycle after N+33, with done=1 and result valid.
  - busy is high from the request cycle through the FIX cycle, which is 34 cycles in total.
- Special-case latency: the request is sampled at edge N, done=1 in the cycle after edge N, and busy is high only in the request cycle.
- Back-to-back divides: the next request is accepted in IDLE, at the earliest one cycle after DONE.
- Simultaneous kill and start in IDLE: the request is not accepted.

## Test plan
- DIVU op_a=100, op_b=7 → done exactly 34 cycles after the request cycle, result=14. busy=1 for 34 cycles, then 0 during the done cycle.
- REM op_a=0xFFFFFFF9 (-7), op_b=2 → result=0xFFFFFFFF (-1). DIV on the same operands → 0xFFFFFFFD (-3).
- DIV op_b=0 → result=0xFFFFFFFF with done in the next cycle. REMU op_a=0x1234, op_b=0 → result=0x1234.
- DIV op_a=0x80000000, op_b=0xFFFFFFFF → result=0x80000000. REM on the same operands → 0. Both have 1-cycle latency.
- Assert rst at CALC iteration 10 → busy=0 immediately and no done pulse. A subsequent DIVU 9/3 returns 3 normally.
- Pulse kill during FIX → IDLE next edge, no done, result unchanged. In a separate run, hold start high through DONE → no second operation is launched.
